mbgd_grad_update: RTL and testbench

- Downstream stage of the hypothesis pipeline in the logistic-regression mini-batch gradient descent (MBGD) datapath.
- Consumes each sample's sigmoid output h together with that sample's feature vector x and its label y.
- Accumulates the per-lane gradient (h - target)*x_i over a mini-batch, then applies a shift-scaled, saturating update to the parameter vector teta.
- Drives the updated teta back to the hypothesis stage.

---
 rtl/mbgd_grad_update.sv | 111 +++++++++++
 tb/tb_mbgd_grad_update.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mbgd_grad_update.sv
// rtl/mbgd_grad_update.sv - MBGD gradient accumulate and saturating teta update
// Sums (h - target) * x_i per lane over 2^MB_BIT samples, then steps teta by acc >>> LR_SHIFT.
module mbgd_grad_update #(
  parameter int DW       = 8,
  parameter int N        = 8,
  parameter int MB_BIT   = 2,
  parameter int LR_SHIFT = 12,
  parameter int ACC_W    = 2*DW + 1 + MB_BIT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] x,
  input  logic [DW-1:0]   h,
  input  logic            y,
  input  logic            teta_load,
  input  logic [N*DW-1:0] teta_in,
  output logic [N*DW-1:0] teta,
  output logic            update_done,
  output logic [15:0]     update_count
);

  localparam int TW = DW + ACC_W;
  localparam logic signed [TW-1:0] SMAX = TW'(2**(DW-1) - 1);
  localparam logic signed [TW-1:0] SMIN = TW'(-(2**(DW-1)));

  typedef enum logic {S_ACC, S_UPD} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [MB_BIT-1:0]          r_cnt;
  logic [N-1:0][ACC_W-1:0]    r_acc;
  logic [N*DW-1:0]            r_teta;
  logic                       r_done;
  logic [15:0]                r_count;

  logic                       w_accept;
  logic signed [DW:0]         w_err;
  logic [N-1:0][2*DW:0]       w_prod;
  logic [N*DW-1:0]            w_teta_upd;

  assign in_ready     = reset && enable && !teta_load && (r_state == S_ACC);
  assign w_accept     = in_valid && in_ready;
  // h and target both fit in DW bits, so the 9-bit difference never overflows.
  assign w_err        = {1'b0, h} - (y ? {1'b0, {DW{1'b1}}} : {(DW+1){1'b0}});
  assign teta         = r_teta;
  assign update_done  = r_done;
  assign update_count = r_count;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic signed [DW-1:0]    w_x;
    logic signed [ACC_W-1:0] w_d;
    logic signed [TW-1:0]    w_diff;

    assign w_x        = x[gi*DW +: DW];
    assign w_prod[gi] = w_err * w_x;
    assign w_d        = $signed(r_acc[gi]) >>> LR_SHIFT;
    assign w_diff     = TW'($signed(r_teta[gi*DW +: DW])) - TW'(w_d);
    assign w_teta_upd[gi*DW +: DW] = (w_diff > SMAX) ? SMAX[DW-1:0] :
                                     (w_diff < SMIN) ? SMIN[DW-1:0] :
                                     w_diff[DW-1:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ACC:   if (w_accept && (r_cnt == '1)) w_state_nxt = S_UPD;
      S_UPD:   if (enable) w_state_nxt = S_ACC;
      default: w_state_nxt = S_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_teta  <= '0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_done <= enable && (r_state == S_UPD);
      if (enable) begin
        if (r_state == S_ACC) begin
          // A load only lands on a batch boundary so a half-built gradient never mixes two tetas.
          if (teta_load && (r_cnt == '0)) r_teta <= teta_in;
          if (w_accept) begin
            r_cnt <= r_cnt + MB_BIT'(1);
            for (int li = 0; li < N; li++) begin
              r_acc[li] <= r_acc[li] + ACC_W'($signed(w_prod[li]));
            end
          end
        end else begin
          r_teta  <= w_teta_upd;
          r_acc   <= '0;
          r_count <= r_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mbgd_grad_update.sv
// tb/tb_mbgd_grad_update.sv - randomized self-checking bench for mbgd_grad_update
// Reference model keeps raw samples per batch and computes the update arithmetically.
module tb_mbgd_grad_update;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] x;
  logic [7:0]  h;
  logic        y;
  logic        teta_load;
  logic [63:0] teta_in;
  logic [63:0] teta;
  logic        update_done;
  logic [15:0] update_count;

  int checks;
  int failures;

  typedef struct {
    logic [63:0] sx;
    logic [7:0]  sh;
    logic        sy;
  } samp_t;

  samp_t q[$];
  int    m_teta[8];
  int    m_count;

  mbgd_grad_update dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .x            (x),
    .h            (h),
    .y            (y),
    .teta_load    (teta_load),
    .teta_in      (teta_in),
    .teta         (teta),
    .update_done  (update_done),
    .update_count (update_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack_teta();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = m_teta[i][7:0];
    return v;
  endfunction

  function automatic void set_teta(input logic [63:0] v);
    for (int i = 0; i < 8; i++) m_teta[i] = int'($signed(v[i*8 +: 8]));
  endfunction

  function automatic void model_apply();
    for (int i = 0; i < 8; i++) begin
      longint a;
      longint d;
      longint t;
      a = 0;
      foreach (q[k]) begin
        a += longint'(int'(q[k].sh) - (q[k].sy ? 255 : 0)) * longint'($signed(q[k].sx[i*8 +: 8]));
      end
      d = a >>> 12;
      t = longint'(m_teta[i]) - d;
      if (t > 127) t = 127;
      if (t < -128) t = -128;
      m_teta[i] = int'(t);
    end
    q.delete();
    m_count = (m_count + 1) & 16'hFFFF;
  endfunction

  function automatic logic [63:0] rand_x();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0:       v[i*8 +: 8] = 8'h7F;
        1:       v[i*8 +: 8] = 8'h80;
        default: v[i*8 +: 8] = 8'($urandom);
      endcase
    end
    return v;
  endfunction

  task automatic send(input logic [63:0] sx, input logic [7:0] sh, input logic sy);
    int    n;
    samp_t s;
    @(negedge clk);
    x = sx; h = sh; y = sy; in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    s.sx = sx; s.sh = sh; s.sy = sy;
    q.push_back(s);
  endtask

  task automatic finish_batch(input int stall);
    logic [63:0] old;
    old = pack_teta();
    model_apply();
    enable = (stall == 0);
    for (int i = 0; i <= stall; i++) begin
      @(negedge clk);
      chk("upd_ready_low", 64'(in_ready), 64'd0);
      chk("upd_done_low", 64'(update_done), 64'd0);
      chk("upd_teta_hold", teta, old);
      if (i == stall) enable = 1'b1;
    end
    @(negedge clk);
    chk("upd_teta", teta, pack_teta());
    chk("upd_done_pulse", 64'(update_done), 64'd1);
    chk("upd_count", 64'(update_count), 64'(m_count));
    chk("upd_ready_back", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("upd_done_single", 64'(update_done), 64'd0);
  endtask

  task automatic batch_fixed(input logic [63:0] sx, input logic [7:0] sh, input logic sy, input int stall);
    for (int k = 0; k < 4; k++) send(sx, sh, sy);
    finish_batch(stall);
  endtask

  task automatic batch_rand(input int stall, input int maxgap);
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
      send(rand_x(), 8'($urandom), 1'($urandom));
    end
    finish_batch(stall);
  endtask

  task automatic load(input logic [63:0] v, input logic with_valid);
    logic take;
    take = (q.size() == 0);
    @(negedge clk);
    teta_in = v; teta_load = 1'b1; in_valid = with_valid; x = rand_x(); h = 8'($urandom); y = 1'($urandom);
    #1;
    chk("load_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    teta_load = 1'b0;
    in_valid  = 1'b0;
    if (take) set_teta(v);
    @(negedge clk);
    chk("load_teta", teta, pack_teta());
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_teta", teta, 64'd0);
    chk("rst_count", 64'(update_count), 64'd0);
    chk("rst_done", 64'(update_done), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    set_teta(64'd0);
    m_count = 0;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; enable = 1'b1; in_valid = 1'b0; x = '0; h = '0; y = 1'b0;
    teta_load = 1'b0; teta_in = '0;
    set_teta(64'd0);
    m_count = 0;
    repeat (3) @(negedge clk);
    chk("init_ready", 64'(in_ready), 64'd0);
    chk("init_done", 64'(update_done), 64'd0);
    reset = 1'b1;

    load(64'd0, 1'b0);
    chk("post_load_count", 64'(update_count), 64'd0);
    chk("post_load_done", 64'(update_done), 64'd0);
    chk("post_load_ready", 64'(in_ready), 64'd1);

    batch_fixed({8{8'h10}}, 8'd255, 1'b0, 0);
    chk("dir_fd_lanes", teta, {8{8'hFD}});
    chk("dir_count1", 64'(update_count), 64'd1);

    load({8{8'h7F}}, 1'b0);
    batch_fixed({8{8'h7F}}, 8'd0, 1'b1, 0);
    chk("dir_pos_sat", teta, {8{8'h7F}});

    load({8{8'h80}}, 1'b0);
    batch_fixed({8{8'h10}}, 8'd255, 1'b0, 0);
    chk("dir_neg_sat", teta, {8{8'h80}});

    load(rand_x(), 1'b1);
    batch_rand(3, 0);

    send(rand_x(), 8'($urandom), 1'($urandom));
    send(rand_x(), 8'($urandom), 1'($urandom));
    load(rand_x(), 1'b0);
    do_reset();
    batch_rand(0, 0);
    chk("fresh_count", 64'(update_count), 64'd1);

    for (int b = 0; b < 10; b++) begin
      if ($urandom_range(0, 1) == 1) load(rand_x(), 1'($urandom));
      batch_rand($urandom_range(0, 2), 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
